// File: rtl/rom_menu_ctrl_if.sv
// rom_menu_ctrl_if
// Groups the button inputs and the loader handshake of the ROM menu
// controller into one bundle.
//   btn_next / btn_prev / btn_load : raw, asynchronous, active-high buttons
//   sd_initialized                 : loader reports the SD card is ready
//   currentROM                     : loader reports the last completed load
//   selectedROM                    : index presented to the loader
//   doLoadRom                      : load request to the loader
//   loading                        : request outstanding
//   load_rejected                  : one-cycle refusal / timeout pulse
// modport slave is the controller side, modport master the driving side.
interface rom_menu_ctrl_if;
  logic        btn_next;
  logic        btn_prev;
  logic        btn_load;
  logic        sd_initialized;
  logic [15:0] currentROM;
  logic [15:0] selectedROM;
  logic        doLoadRom;
  logic        loading;
  logic        load_rejected;

  modport master (
    output btn_next, btn_prev, btn_load, sd_initialized, currentROM,
    input  selectedROM, doLoadRom, loading, load_rejected
  );

  modport slave (
    input  btn_next, btn_prev, btn_load, sd_initialized, currentROM,
    output selectedROM, doLoadRom, loading, load_rejected
  );
endinterface

// File: rtl/rom_menu_ctrl.sv
// rom_menu_ctrl
// Cartridge-selection front end for the SD-to-SRAM ROM loader. Debounces
// the next/prev/load buttons, auto-repeats held next/prev keys, keeps a
// wrapped ROM index and sequences the doLoadRom/selectedROM handshake,
// freezing the index until the loader reports the new currentROM.
// Ports:
//   clk   : system clock (shared with the loader)
//   reset : asynchronous, active-high
//   bus   : rom_menu_ctrl_if.slave (buttons in, loader handshake in/out)
module rom_menu_ctrl #(
  parameter logic [15:0] NUM_ROMS        = 16'd256,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd12000000,
  parameter logic [23:0] REPEAT_RATE     = 24'd3000000,
  parameter logic [7:0]  LOAD_PULSE      = 8'd16,
  parameter logic [23:0] WAIT_TIMEOUT    = 24'd16000000,
  parameter logic        AUTOLOAD        = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  rom_menu_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Button bit order everywhere: [0]=next, [1]=prev, [2]=load
  logic [2:0]  raw_s;
  logic [2:0]  sync1_r;
  logic [2:0]  sync2_r;
  logic [2:0]  deb_r;
  logic [2:0]  deb_prev_r;
  logic [19:0] deb_cnt_r [3];
  logic [2:0]  rise_s;

  logic        both_s;
  logic [23:0] rep_cnt_r [2];
  logic [1:0]  rep_phase_r;
  logic [1:0]  rep_fire_s;
  logic [1:0]  step_s;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [15:0] sel_r;
  logic [15:0] sel_nxt_s;
  logic        do_load_r;
  logic        do_load_nxt_s;
  logic        loading_r;
  logic        rejected_r;
  logic        rejected_nxt_s;
  logic        armed_r;
  logic        armed_nxt_s;
  logic [7:0]  pulse_cnt_r;
  logic [7:0]  pulse_cnt_nxt_s;
  logic [23:0] wait_cnt_r;
  logic [23:0] wait_cnt_nxt_s;
  logic        load_req_s;

  assign raw_s  = {bus.btn_load, bus.btn_prev, bus.btn_next};
  assign rise_s = deb_r & ~deb_prev_r;
  assign both_s = deb_r[0] & deb_r[1];

  // Synchronize the raw buttons and debounce each one against its stable level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r    <= 3'b000;
      sync2_r    <= 3'b000;
      deb_r      <= 3'b000;
      deb_prev_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_r[i] <= 20'd0;
      end
    end else begin
      sync1_r    <= raw_s;
      sync2_r    <= sync1_r;
      deb_prev_r <= deb_r;
      for (int i = 0; i < 3; i++) begin
        // The counter only runs while the input disagrees with the level
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= 20'd0;
        end else if (deb_cnt_r[i] == DEBOUNCE_CYCLES - 20'd1) begin
          deb_cnt_r[i] <= 20'd0;
          deb_r[i]     <= sync2_r[i];
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + 20'd1;
        end
      end
    end
  end

  // Decide repeat steps and combine them with press edges into index steps
  always_comb begin
    rep_fire_s = 2'b00;
    step_s     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (rep_phase_r[i]) begin
        rep_fire_s[i] = deb_r[i] & ~both_s & (rep_cnt_r[i] == REPEAT_RATE);
      end else begin
        rep_fire_s[i] = deb_r[i] & ~both_s & (rep_cnt_r[i] == REPEAT_DELAY);
      end
      step_s[i] = ~both_s & (rise_s[i] | rep_fire_s[i]);
    end
  end

  // Count hold time for next/prev; counter is 0 in the press-edge cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_phase_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rep_cnt_r[i] <= 24'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!deb_r[i] || both_s) begin
          rep_cnt_r[i]   <= 24'd0;
          rep_phase_r[i] <= 1'b0;
        end else if (rep_fire_s[i]) begin
          // Restart at 1 so the next fire lands exactly REPEAT_RATE later
          rep_cnt_r[i]   <= 24'd1;
          rep_phase_r[i] <= 1'b1;
        end else begin
          rep_cnt_r[i]   <= rep_cnt_r[i] + 24'd1;
        end
      end
    end
  end

  assign load_req_s = rise_s[2] | (armed_r & bus.sd_initialized);

  // Load FSM next-state, index arithmetic and handshake decisions
  always_comb begin
    state_nxt_s     = state_r;
    sel_nxt_s       = sel_r;
    do_load_nxt_s   = 1'b0;
    rejected_nxt_s  = 1'b0;
    armed_nxt_s     = armed_r;
    pulse_cnt_nxt_s = pulse_cnt_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    case (state_r)
      ST_IDLE: begin
        pulse_cnt_nxt_s = 8'd0;
        wait_cnt_nxt_s  = 24'd0;
        // A load request takes priority and swallows any same-cycle step
        if (load_req_s) begin
          if (bus.sd_initialized) begin
            state_nxt_s   = ST_PULSE;
            do_load_nxt_s = 1'b1;
            armed_nxt_s   = 1'b0;
          end else begin
            rejected_nxt_s = 1'b1;
          end
        end else if (step_s[0]) begin
          if (sel_r >= NUM_ROMS - 16'd1) begin
            sel_nxt_s = 16'd0;
          end else begin
            sel_nxt_s = sel_r + 16'd1;
          end
        end else if (step_s[1]) begin
          if (sel_r == 16'd0) begin
            sel_nxt_s = NUM_ROMS - 16'd1;
          end else begin
            sel_nxt_s = sel_r - 16'd1;
          end
        end else begin
          sel_nxt_s = sel_r;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_r == LOAD_PULSE - 8'd1) begin
          state_nxt_s     = ST_WAIT;
          pulse_cnt_nxt_s = 8'd0;
        end else begin
          do_load_nxt_s   = 1'b1;
          pulse_cnt_nxt_s = pulse_cnt_r + 8'd1;
        end
      end
      ST_WAIT: begin
        // Minimum dwell keeps a match left over from the previous load from ending the wait early
        if ((bus.currentROM == sel_r) && (wait_cnt_r >= 24'd8)) begin
          state_nxt_s = ST_IDLE;
        end else if (!bus.sd_initialized || (wait_cnt_r == WAIT_TIMEOUT - 24'd1)) begin
          state_nxt_s    = ST_IDLE;
          rejected_nxt_s = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 24'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Register FSM state, index and all handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      sel_r       <= 16'd0;
      do_load_r   <= 1'b0;
      loading_r   <= 1'b0;
      rejected_r  <= 1'b0;
      armed_r     <= AUTOLOAD;
      pulse_cnt_r <= 8'd0;
      wait_cnt_r  <= 24'd0;
    end else begin
      state_r     <= state_nxt_s;
      sel_r       <= sel_nxt_s;
      do_load_r   <= do_load_nxt_s;
      loading_r   <= (state_nxt_s != ST_IDLE);
      rejected_r  <= rejected_nxt_s;
      armed_r     <= armed_nxt_s;
      pulse_cnt_r <= pulse_cnt_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
    end
  end

  assign bus.selectedROM   = sel_r;
  assign bus.doLoadRom     = do_load_r;
  assign bus.loading       = loading_r;
  assign bus.load_rejected = rejected_r;

endmodule

// File: tb/tb_rom_menu_ctrl.sv
// tb_rom_menu_ctrl
// Directed bench for rom_menu_ctrl with NUM_ROMS=5, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_RATE=10, LOAD_PULSE=16, WAIT_TIMEOUT=50.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rom_menu_ctrl;
  logic        clk;
  logic        reset;
  int          assertions = 0;
  int          failures = 0;
  int          sel_changes = 0;
  logic [15:0] prev_sel = 16'd0;

  rom_menu_ctrl_if bus_if ();

  rom_menu_ctrl #(
    .NUM_ROMS        (16'd5),
    .DEBOUNCE_CYCLES (20'd4),
    .REPEAT_DELAY    (24'd20),
    .REPEAT_RATE     (24'd10),
    .LOAD_PULSE      (8'd16),
    .WAIT_TIMEOUT    (24'd50),
    .AUTOLOAD        (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every change of selectedROM seen at a falling edge
  always @(negedge clk) begin
    if (bus_if.selectedROM !== prev_sel) sel_changes++;
    prev_sel = bus_if.selectedROM;
  end

  task automatic press(input int which, input int cycles);
    if (which == 0) bus_if.btn_next = 1'b1;
    else if (which == 1) bus_if.btn_prev = 1'b1;
    else bus_if.btn_load = 1'b1;
    repeat (cycles) @(negedge clk);
    bus_if.btn_next = 1'b0;
    bus_if.btn_prev = 1'b0;
    bus_if.btn_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.btn_next = 1'b0;
    bus_if.btn_prev = 1'b0;
    bus_if.btn_load = 1'b0;
    bus_if.sd_initialized = 1'b0;
    bus_if.currentROM = 16'h00FF;
    repeat (3) @(negedge clk);
    assertions++;
    if (bus_if.selectedROM !== 16'd0) begin failures++; $display("FAIL reset_sel: got %0d, expected 0", bus_if.selectedROM); end
    assertions++;
    if (bus_if.doLoadRom !== 1'b0) begin failures++; $display("FAIL reset_doload: got %b, expected 0", bus_if.doLoadRom); end
    assertions++;
    if (bus_if.loading !== 1'b0) begin failures++; $display("FAIL reset_loading: got %b, expected 0", bus_if.loading); end
    assertions++;
    if (bus_if.load_rejected !== 1'b0) begin failures++; $display("FAIL reset_rejected: got %b, expected 0", bus_if.load_rejected); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reject();
    int rej_cnt = 0;
    int rej_first = -1;
    int dl_cnt = 0;
    int ld_cnt = 0;
    bus_if.btn_load = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 8) bus_if.btn_load = 1'b0;
      if (bus_if.load_rejected === 1'b1) begin
        rej_cnt++;
        if (rej_first < 0) rej_first = i;
      end
      if (bus_if.doLoadRom === 1'b1) dl_cnt++;
      if (bus_if.loading === 1'b1) ld_cnt++;
    end
    assertions++;
    if (rej_first !== 7) begin failures++; $display("FAIL reject_latency: got %0d, expected 7", rej_first); end
    assertions++;
    if (rej_cnt !== 1) begin failures++; $display("FAIL reject_width: got %0d, expected 1", rej_cnt); end
    assertions++;
    if (dl_cnt !== 0) begin failures++; $display("FAIL reject_doload: got %0d, expected 0", dl_cnt); end
    assertions++;
    if (ld_cnt !== 0) begin failures++; $display("FAIL reject_loading: got %0d, expected 0", ld_cnt); end
  endtask

  task automatic test_autoload();
    int n = 0;
    int width = 0;
    int k = 0;
    int extra = 0;
    bus_if.sd_initialized = 1'b1;
    while (bus_if.doLoadRom !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    assertions++;
    if (n !== 1) begin failures++; $display("FAIL autoload_latency: got %0d, expected 1", n); end
    assertions++;
    if (bus_if.selectedROM !== 16'd0) begin failures++; $display("FAIL autoload_index: got %0d, expected 0", bus_if.selectedROM); end
    while (bus_if.doLoadRom === 1'b1 && width < 100) begin
      width++;
      @(negedge clk);
    end
    assertions++;
    if (width !== 16) begin failures++; $display("FAIL autoload_width: got %0d, expected 16", width); end
    bus_if.currentROM = 16'd0;
    while (bus_if.loading === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    assertions++;
    if (k !== 9) begin failures++; $display("FAIL autoload_dwell: got %0d, expected 9", k); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.doLoadRom === 1'b1 || bus_if.load_rejected === 1'b1) extra++;
    end
    assertions++;
    if (extra !== 0) begin failures++; $display("FAIL autoload_once: got %0d, expected 0", extra); end
  endtask

  task automatic test_debounce();
    int base = sel_changes;
    for (int g = 0; g < 3; g++) begin
      press(0, 2);
      repeat (2) @(negedge clk);
    end
    press(0, 8);
    repeat (15) @(negedge clk);
    assertions++;
    if (sel_changes - base !== 1) begin failures++; $display("FAIL debounce_steps: got %0d, expected 1", sel_changes - base); end
    assertions++;
    if (bus_if.selectedROM !== 16'd1) begin failures++; $display("FAIL debounce_index: got %0d, expected 1", bus_if.selectedROM); end
  endtask

  task automatic test_wrap();
    int          dir [4];
    logic [15:0] exp_idx [4];
    dir = '{1, 1, 0, 1};
    exp_idx = '{16'd0, 16'd4, 16'd0, 16'd4};
    for (int i = 0; i < 4; i++) begin
      press(dir[i], 8);
      repeat (10) @(negedge clk);
      assertions++;
      if (bus_if.selectedROM !== exp_idx[i]) begin
        failures++;
        $display("FAIL wrap_step%0d: got %0d, expected %0d", i, bus_if.selectedROM, exp_idx[i]);
      end
    end
  endtask

  task automatic test_repeat();
    int base = sel_changes;
    press(0, 45);
    repeat (15) @(negedge clk);
    assertions++;
    if (sel_changes - base !== 4) begin failures++; $display("FAIL repeat_steps: got %0d, expected 4", sel_changes - base); end
    assertions++;
    if (bus_if.selectedROM !== 16'd3) begin failures++; $display("FAIL repeat_index: got %0d, expected 3", bus_if.selectedROM); end
  endtask

  task automatic test_load();
    int n = 0;
    int width = 0;
    int k = 0;
    int sel_bad = 0;
    int dl_bad = 0;
    bus_if.btn_load = 1'b1;
    while (bus_if.doLoadRom !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    assertions++;
    if (n !== 7) begin failures++; $display("FAIL load_latency: got %0d, expected 7", n); end
    while (bus_if.doLoadRom === 1'b1 && width < 100) begin
      if (bus_if.selectedROM !== 16'd3) sel_bad++;
      if (width == 0) begin bus_if.btn_load = 1'b0; bus_if.btn_next = 1'b1; end
      if (width == 8) bus_if.btn_next = 1'b0;
      width++;
      @(negedge clk);
    end
    bus_if.btn_load = 1'b0;
    bus_if.btn_next = 1'b0;
    assertions++;
    if (width !== 16) begin failures++; $display("FAIL load_width: got %0d, expected 16", width); end
    assertions++;
    if (bus_if.loading !== 1'b1) begin failures++; $display("FAIL load_wait_loading: got %b, expected 1", bus_if.loading); end
    bus_if.btn_prev = 1'b1;
    while (bus_if.loading === 1'b1 && k < 100) begin
      if (bus_if.selectedROM !== 16'd3) sel_bad++;
      if (bus_if.doLoadRom !== 1'b0) dl_bad++;
      @(negedge clk);
      k++;
      if (k == 8) bus_if.btn_prev = 1'b0;
      if (k == 20) bus_if.currentROM = 16'd3;
    end
    bus_if.btn_prev = 1'b0;
    assertions++;
    if (k !== 21) begin failures++; $display("FAIL load_match_cycle: got %0d, expected 21", k); end
    assertions++;
    if (sel_bad !== 0) begin failures++; $display("FAIL load_sel_frozen: got %0d bad samples, expected 0", sel_bad); end
    assertions++;
    if (dl_bad !== 0) begin failures++; $display("FAIL load_wait_doload: got %0d bad samples, expected 0", dl_bad); end
    repeat (30) @(negedge clk);
    assertions++;
    if (bus_if.selectedROM !== 16'd3) begin failures++; $display("FAIL load_index_after: got %0d, expected 3", bus_if.selectedROM); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int width = 0;
    int k = 0;
    bus_if.currentROM = 16'd9;
    bus_if.btn_load = 1'b1;
    while (bus_if.doLoadRom !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    bus_if.btn_load = 1'b0;
    while (bus_if.doLoadRom === 1'b1 && width < 100) begin
      width++;
      @(negedge clk);
    end
    assertions++;
    if (width !== 16) begin failures++; $display("FAIL timeout_width: got %0d, expected 16", width); end
    while (bus_if.load_rejected !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    assertions++;
    if (k !== 50) begin failures++; $display("FAIL timeout_cycle: got %0d, expected 50", k); end
    assertions++;
    if (bus_if.loading !== 1'b0) begin failures++; $display("FAIL timeout_loading: got %b, expected 0", bus_if.loading); end
    @(negedge clk);
    assertions++;
    if (bus_if.load_rejected !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width: got %b, expected 0", bus_if.load_rejected); end
    assertions++;
    if (bus_if.selectedROM !== 16'd3) begin failures++; $display("FAIL timeout_index: got %0d, expected 3", bus_if.selectedROM); end
  endtask

  task automatic test_reset_mid_pulse();
    int n = 0;
    bus_if.btn_load = 1'b1;
    while (bus_if.doLoadRom !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    bus_if.btn_load = 1'b0;
    repeat (4) @(negedge clk);
    assertions++;
    if (bus_if.doLoadRom !== 1'b1) begin failures++; $display("FAIL midpulse_pre: got %b, expected 1", bus_if.doLoadRom); end
    #2;
    reset = 1'b1;
    bus_if.sd_initialized = 1'b0;
    #1;
    assertions++;
    if (bus_if.doLoadRom !== 1'b0) begin failures++; $display("FAIL midpulse_doload: got %b, expected 0", bus_if.doLoadRom); end
    assertions++;
    if (bus_if.selectedROM !== 16'd0) begin failures++; $display("FAIL midpulse_index: got %0d, expected 0", bus_if.selectedROM); end
    assertions++;
    if (bus_if.loading !== 1'b0) begin failures++; $display("FAIL midpulse_loading: got %b, expected 0", bus_if.loading); end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_sd_drop();
    int n = 0;
    int width = 0;
    int k = 0;
    bus_if.sd_initialized = 1'b1;
    while (bus_if.doLoadRom !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    assertions++;
    if (n !== 1) begin failures++; $display("FAIL sddrop_autoload_latency: got %0d, expected 1", n); end
    while (bus_if.doLoadRom === 1'b1 && width < 100) begin
      width++;
      @(negedge clk);
    end
    while (bus_if.load_rejected !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 3) bus_if.sd_initialized = 1'b0;
    end
    assertions++;
    if (k !== 4) begin failures++; $display("FAIL sddrop_cycle: got %0d, expected 4", k); end
    assertions++;
    if (bus_if.loading !== 1'b0) begin failures++; $display("FAIL sddrop_loading: got %b, expected 0", bus_if.loading); end
  endtask

  initial begin
    test_reset();
    test_reject();
    test_autoload();
    test_debounce();
    test_wrap();
    test_repeat();
    test_load();
    test_timeout();
    test_reset_mid_pulse();
    test_sd_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
